// File: rtl/usb_utmi_pkg.sv
// usb_utmi_pkg: shared UTMI types for the FS UTM.
// Line-state encoding, receive FSM states, SYNC pattern.
package usb_utmi_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } utmi_line_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_SYNC,
    RX_DATA,
    RX_EOP,
    RX_ABORT
  } usb_rx_state_t;

  // Received LSB-first as 0000_0001
  localparam logic [7:0] USB_SYNC_PATTERN = 8'h80;

endpackage

// File: rtl/usb_utm_rx_ctrl_if.sv
// usb_utm_rx_ctrl_if: receive-side bundle of the FS UTM.
// master drives line/bit strobes, slave is the rx sequencer.
interface usb_utm_rx_ctrl_if;
  import usb_utmi_pkg::*;

  logic             rx_en;
  utmi_line_state_t line_state;
  logic             ls_valid;
  logic             dbit;
  logic             dbit_valid;
  logic             stuff_err;
  logic             rx_active;
  logic             rx_valid;
  logic             rx_error;
  logic [7:0]       data_out;

  modport master (
    output rx_en,
    output line_state,
    output ls_valid,
    output dbit,
    output dbit_valid,
    output stuff_err,
    input  rx_active,
    input  rx_valid,
    input  rx_error,
    input  data_out
  );

  modport slave (
    input  rx_en,
    input  line_state,
    input  ls_valid,
    input  dbit,
    input  dbit_valid,
    input  stuff_err,
    output rx_active,
    output rx_valid,
    output rx_error,
    output data_out
  );

endinterface

// File: rtl/usb_utm_rx_ctrl.sv
// usb_utm_rx_ctrl: FS UTM receive sequencer.
// SYNC detect, LSB-first byte assembly, EOP and abort recovery.
module usb_utm_rx_ctrl
  import usb_utmi_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS = 3,
  parameter int DRIBBLE_MAX    = 1,
  parameter int EOP_MAX_SE0    = 2,
  parameter int IDLE_J_BITS    = 8
) (
  input  logic             clk,
  input  logic             rst,
  usb_utm_rx_ctrl_if.slave rx_if
);

  localparam int SW = $clog2(EOP_MAX_SE0 + 2);
  localparam int JW = $clog2(IDLE_J_BITS + 1);

  usb_rx_state_t r_state;
  usb_rx_state_t w_state_nxt;

  logic [2:0]    r_zero_cnt;
  logic [2:0]    w_zero_cnt_nxt;
  logic [2:0]    r_bit_cnt;
  logic [2:0]    w_bit_cnt_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic [SW-1:0] r_se0_cnt;
  logic [SW-1:0] w_se0_cnt_nxt;
  logic [JW-1:0] r_j_cnt;
  logic [JW-1:0] w_j_cnt_nxt;

  logic          r_rx_active;
  logic          w_rx_active_nxt;
  logic          r_rx_valid;
  logic          w_rx_valid_nxt;
  logic          r_rx_error;
  logic          w_rx_error_nxt;
  logic [7:0]    r_data;
  logic [7:0]    w_data_nxt;

  logic          w_se0;
  logic          w_se1;
  logic          w_j;
  logic          w_k;
  logic          w_se;
  logic          w_sync_ok;
  logic          w_dribble_ok;
  logic          w_data_abort;
  logic [SW-1:0] w_se0_inc;
  logic          w_se0_over;
  logic [JW-1:0] w_j_inc;
  logic          w_j_done;

  assign w_se0 = rx_if.ls_valid && (rx_if.line_state == LS_SE0);
  assign w_se1 = rx_if.ls_valid && (rx_if.line_state == LS_SE1);
  assign w_j   = rx_if.ls_valid && (rx_if.line_state == LS_J);
  assign w_k   = rx_if.ls_valid && (rx_if.line_state == LS_K);
  assign w_se  = w_se0 || w_se1;

  assign w_sync_ok    = r_zero_cnt >= 3'(SYNC_MIN_ZEROS);
  assign w_dribble_ok = r_bit_cnt <= 3'(DRIBBLE_MAX);
  assign w_data_abort = rx_if.stuff_err || w_se1;

  assign w_se0_inc  = r_se0_cnt + SW'(1);
  assign w_se0_over = w_se0_inc > SW'(EOP_MAX_SE0);
  assign w_j_inc    = r_j_cnt + JW'(1);
  assign w_j_done   = w_j_inc == JW'(IDLE_J_BITS);

  assign rx_if.rx_active = r_rx_active;
  assign rx_if.rx_valid  = r_rx_valid;
  assign rx_if.rx_error  = r_rx_error;
  assign rx_if.data_out  = r_data;

  // State, counters and registered UTMI outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RX_IDLE;
      r_zero_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_se0_cnt   <= '0;
      r_j_cnt     <= '0;
      r_rx_active <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_error  <= 1'b0;
      r_data      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_zero_cnt  <= w_zero_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_se0_cnt   <= w_se0_cnt_nxt;
      r_j_cnt     <= w_j_cnt_nxt;
      r_rx_active <= w_rx_active_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_rx_error  <= w_rx_error_nxt;
      r_data      <= w_data_nxt;
    end
  end

  // Next state; rx_en low beats every line event
  always_comb begin
    w_state_nxt = r_state;
    if (!rx_if.rx_en) begin
      w_state_nxt = RX_IDLE;
    end else begin
      unique case (r_state)
        RX_IDLE: begin
          if (w_k) w_state_nxt = RX_SYNC;
        end
        RX_SYNC: begin
          if (w_se) begin
            w_state_nxt = RX_IDLE;
          end else if (rx_if.dbit_valid && rx_if.dbit) begin
            w_state_nxt = w_sync_ok ? RX_DATA : RX_IDLE;
          end
        end
        RX_DATA: begin
          if (w_data_abort) begin
            w_state_nxt = RX_ABORT;
          end else if (w_se0) begin
            w_state_nxt = RX_EOP;
          end
        end
        RX_EOP: begin
          if (w_se0) begin
            if (w_se0_over) w_state_nxt = RX_ABORT;
          end else if (w_j) begin
            w_state_nxt = RX_IDLE;
          end else if (w_k || w_se1) begin
            w_state_nxt = RX_ABORT;
          end
        end
        RX_ABORT: begin
          if (w_j && w_j_done) w_state_nxt = RX_IDLE;
        end
        default: w_state_nxt = RX_IDLE;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    w_zero_cnt_nxt  = r_zero_cnt;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_se0_cnt_nxt   = r_se0_cnt;
    w_j_cnt_nxt     = r_j_cnt;
    w_rx_active_nxt = r_rx_active;
    w_rx_valid_nxt  = 1'b0;
    w_rx_error_nxt  = 1'b0;
    w_data_nxt      = r_data;
    if (!rx_if.rx_en) begin
      w_zero_cnt_nxt  = '0;
      w_bit_cnt_nxt   = '0;
      w_shift_nxt     = '0;
      w_se0_cnt_nxt   = '0;
      w_j_cnt_nxt     = '0;
      w_rx_active_nxt = 1'b0;
    end else begin
      unique case (r_state)
        RX_IDLE: begin
          w_rx_active_nxt = 1'b0;
          // The J->K edge is itself the first SYNC zero
          if (w_k) w_zero_cnt_nxt = 3'd1;
        end
        RX_SYNC: begin
          if (!w_se && rx_if.dbit_valid) begin
            if (!rx_if.dbit) begin
              if (r_zero_cnt != 3'd7) begin
                w_zero_cnt_nxt = r_zero_cnt + 3'd1;
              end
            end else if (w_sync_ok) begin
              w_rx_active_nxt = 1'b1;
              w_bit_cnt_nxt   = '0;
              w_shift_nxt     = '0;
            end
          end
        end
        RX_DATA: begin
          if (w_data_abort) begin
            w_rx_error_nxt = 1'b1;
            w_j_cnt_nxt    = '0;
          end else if (w_se0) begin
            w_se0_cnt_nxt  = SW'(1);
            w_rx_error_nxt = !w_dribble_ok;
          end else if (rx_if.dbit_valid) begin
            w_shift_nxt   = {rx_if.dbit, r_shift[7:1]};
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_data_nxt     = {rx_if.dbit, r_shift[7:1]};
              w_rx_valid_nxt = 1'b1;
            end
          end
        end
        RX_EOP: begin
          if (w_se0) begin
            w_se0_cnt_nxt = w_se0_inc;
            if (w_se0_over) begin
              w_rx_error_nxt = 1'b1;
              w_j_cnt_nxt    = '0;
            end
          end else if (w_j) begin
            w_rx_active_nxt = 1'b0;
          end else if (w_k || w_se1) begin
            w_rx_error_nxt = 1'b1;
            w_j_cnt_nxt    = '0;
          end
        end
        RX_ABORT: begin
          // rx_active drops the clk after the error pulse
          w_rx_active_nxt = 1'b0;
          if (w_j) begin
            w_j_cnt_nxt = w_j_done ? '0 : w_j_inc;
          end else if (rx_if.ls_valid) begin
            w_j_cnt_nxt = '0;
          end
        end
        default: begin
          w_rx_active_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_utm_rx_ctrl.sv
// tb_usb_utm_rx_ctrl: packet-level bench for the rx sequencer.
// NRZI/stuffing encoder drives strobes; scoreboard checks events.
module tb_usb_utm_rx_ctrl;
  import usb_utmi_pkg::*;

  localparam int DRIBBLE_MAX = 1;
  localparam int EOP_MAX_SE0 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  usb_utm_rx_ctrl_if rx_if();

  usb_utm_rx_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (rx_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  rises  = 0;
  logic prev_act = 1'b0;

  utmi_line_state_t lvl = LS_J;
  int         ones = 0;
  int         nbits = 0;
  logic [7:0] acc = '0;
  bit         in_pkt = 0;
  bit         quiet = 0;
  bit         aborted = 0;
  logic       s_act0, s_act1, s_err1, s_act2;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Monitor: pops the scoreboard on every rx_valid / rx_error pulse
  always @(negedge clk) begin : mon
    ev_t e;
    if (rst) begin
      prev_act = 1'b0;
    end else begin
      if (rx_if.rx_active && !prev_act) rises++;
      prev_act = rx_if.rx_active;
      if (rx_if.rx_valid || rx_if.rx_error) begin
        chk("valid_error_exclusive",
            32'(rx_if.rx_valid & rx_if.rx_error), 0);
        if (rx_if.rx_valid)
          chk("active_during_valid", 32'(rx_if.rx_active), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: valid=%0b error=%0b data=%02h, expected none",
                   rx_if.rx_valid, rx_if.rx_error, rx_if.data_out);
        end else begin
          e = exp_q.pop_front();
          chk("event_is_error", 32'(rx_if.rx_error), 32'(e.is_err));
          if (!e.is_err)
            chk("data_out", 32'(rx_if.data_out), 32'(e.data));
        end
      end
    end
  end

  function automatic utmi_line_state_t flip(utmi_line_state_t l);
    return (l == LS_J) ? LS_K : LS_J;
  endfunction

  function automatic void push_ev(bit e, logic [7:0] d);
    if (!quiet) exp_q.push_back('{is_err: e, data: d});
  endfunction

  // One bit time: strobe on the first of four clocks
  task automatic sym(utmi_line_state_t ls, bit d, bit dv, bit se);
    rx_if.line_state = ls;
    rx_if.ls_valid   = 1'b1;
    rx_if.dbit       = d;
    rx_if.dbit_valid = dv;
    rx_if.stuff_err  = se;
    s_act0 = rx_if.rx_active;
    @(posedge clk); #1;
    s_act1 = rx_if.rx_active;
    s_err1 = rx_if.rx_error;
    rx_if.ls_valid   = 1'b0;
    rx_if.dbit_valid = 1'b0;
    rx_if.stuff_err  = 1'b0;
    @(posedge clk); #1;
    s_act2 = rx_if.rx_active;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Reference: every 8 counted bits after SYNC form one byte
  task automatic model_bit(bit b);
    if (in_pkt) begin
      acc = {b, acc[7:1]};
      nbits++;
      if (nbits % 8 == 0) push_ev(1'b0, acc);
    end
  endtask

  task automatic send_bit(bit b);
    if (!b) lvl = flip(lvl);
    ones = b ? ones + 1 : 0;
    model_bit(b);
    sym(lvl, b, 1'b1, 1'b0);
    if (ones == 6) begin
      lvl  = flip(lvl);
      ones = 0;
      sym(lvl, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic send_byte(logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_sync();
    logic [7:0] p;
    p = USB_SYNC_PATTERN;
    in_pkt = 0;
    ones = 0;
    for (int i = 0; i < 8; i++) send_bit(p[i]);
    in_pkt = 1;
    nbits = 0;
  endtask

  // Unstuffed run of ones; the seventh raises stuff_err
  task automatic send_stuff_err();
    while (ones < 6) begin
      ones++;
      model_bit(1'b1);
      sym(lvl, 1'b1, 1'b1, 1'b0);
    end
    push_ev(1'b1, 8'h00);
    aborted = 1;
    sym(lvl, 1'b1, 1'b1, 1'b1);
    in_pkt = 0;
  endtask

  task automatic send_eop(int n_se0, bit end_k);
    bit ab;
    ab = aborted;
    for (int i = 0; i < n_se0; i++) begin
      if (!ab) begin
        if (i == 0 && (nbits % 8) > DRIBBLE_MAX) push_ev(1'b1, 8'h00);
        if (i + 1 > EOP_MAX_SE0) begin
          push_ev(1'b1, 8'h00);
          ab = 1;
        end
      end
      sym(LS_SE0, 1'b0, 1'b0, 1'b0);
    end
    if (end_k) begin
      if (!ab) push_ev(1'b1, 8'h00);
      sym(LS_K, 1'b0, 1'b0, 1'b0);
    end else begin
      sym(LS_J, 1'b0, 1'b0, 1'b0);
    end
    lvl = LS_J;
    ones = 0;
    in_pkt = 0;
    aborted = 0;
  endtask

  task automatic idle(int n);
    repeat (n) sym(LS_J, 1'b1, 1'b1, 1'b0);
    lvl = LS_J;
    ones = 0;
  endtask

  initial begin
    int r0;
    int kind;
    int nb;
    rx_if.rx_en      = 1'b1;
    rx_if.line_state = LS_J;
    rx_if.ls_valid   = 1'b0;
    rx_if.dbit       = 1'b0;
    rx_if.dbit_valid = 1'b0;
    rx_if.stuff_err  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state",
        {rx_if.rx_active, rx_if.rx_valid, rx_if.rx_error, rx_if.data_out}, 0);
    rst = 1'b0;
    idle(4);
    chk("idle_after_reset", {rx_if.rx_active, rx_if.data_out}, 0);

    // Single byte, timing of rx_active edges
    send_sync();
    chk("t1_active_rise", {s_act0, s_act1}, 2'b01);
    send_byte(8'hA5);
    send_eop(2, 0);
    chk("t1_active_fall", {s_act0, s_act1}, 2'b10);
    idle(10);
    chk("t1_drain", exp_q.size(), 0);

    // Two bytes, second needs a stuffed bit
    r0 = rises;
    send_sync();
    send_byte(8'hC3);
    send_byte(8'h3F);
    send_eop(2, 0);
    idle(10);
    chk("t2_rise", rises - r0, 1);
    chk("t2_drain", exp_q.size(), 0);

    // Stuff error, 7 J + K keeps ABORT, 8+ J returns to IDLE
    send_sync();
    send_stuff_err();
    chk("t3_err_then_drop", {s_err1, s_act1, s_act2}, 3'b110);
    sym(LS_SE0, 1'b0, 1'b0, 1'b0);
    sym(LS_SE0, 1'b0, 1'b0, 1'b0);
    repeat (7) sym(LS_J, 1'b1, 1'b1, 1'b0);
    sym(LS_K, 1'b0, 1'b1, 1'b0);
    lvl = LS_K;
    ones = 0;
    r0 = rises;
    quiet = 1;
    send_sync();
    send_byte(8'($urandom));
    send_eop(2, 0);
    quiet = 0;
    idle(10);
    chk("t3_abort_held", rises - r0, 0);
    r0 = rises;
    send_sync();
    send_byte(8'h96);
    send_eop(2, 0);
    idle(10);
    chk("t3_recovered", rises - r0, 1);
    chk("t3_drain", exp_q.size(), 0);

    // Dribble: 3 residual bits error, 1 residual bit tolerated
    send_sync();
    send_byte(8'h71);
    repeat (3) send_bit(1'b0);
    send_eop(2, 0);
    idle(10);
    send_sync();
    send_byte(8'h2E);
    send_bit(1'b1);
    send_eop(2, 0);
    idle(10);
    chk("t4_drain", exp_q.size(), 0);

    // SYNC glitches with too few zeros
    r0 = rises;
    sym(LS_K, 1'b0, 1'b1, 1'b0);
    sym(LS_K, 1'b1, 1'b1, 1'b0);
    idle(10);
    sym(LS_K, 1'b0, 1'b1, 1'b0);
    sym(LS_J, 1'b0, 1'b1, 1'b0);
    sym(LS_J, 1'b1, 1'b1, 1'b0);
    idle(10);
    chk("t5_glitch_no_active", rises - r0, 0);
    send_sync();
    send_byte(8'h5C);
    send_eop(2, 0);
    idle(10);
    chk("t5_rise_after_glitch", rises - r0, 1);

    // rx_en dropped mid-byte
    send_sync();
    repeat (4) send_bit(1'($urandom_range(0, 1)));
    chk("t6_active_before_en", 32'(rx_if.rx_active), 1);
    rx_if.rx_en = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_active_en_drop", 32'(rx_if.rx_active), 0);
    quiet = 1;
    repeat (4) send_bit(1'($urandom_range(0, 1)));
    send_eop(2, 0);
    quiet = 0;
    idle(2);
    rx_if.rx_en = 1'b1;
    idle(10);
    chk("t6_en_drain", exp_q.size(), 0);

    // Asynchronous reset mid-byte
    send_sync();
    send_byte(8'h5A);
    repeat (3) send_bit(1'b0);
    chk("t6_pre_rst", {rx_if.rx_active, rx_if.data_out}, 9'h15A);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_async",
        {rx_if.rx_active, rx_if.rx_valid, rx_if.rx_error, rx_if.data_out}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    lvl = LS_J;
    ones = 0;
    in_pkt = 0;
    idle(10);

    // Randomised packets
    for (int p = 0; p < 25; p++) begin
      kind = int'($urandom_range(0, 9));
      nb = int'($urandom_range(1, 3));
      r0 = rises;
      send_sync();
      if (kind < 2) begin
        for (int b = 0; b < nb - 1; b++) send_byte(8'($urandom));
        repeat ($urandom_range(0, 5)) send_bit(1'($urandom_range(0, 1)));
        send_stuff_err();
        send_eop(2, 0);
      end else begin
        for (int b = 0; b < nb; b++) send_byte(8'($urandom));
        repeat ($urandom_range(0, 3)) send_bit(1'($urandom_range(0, 1)));
        send_eop(int'($urandom_range(1, 3)), kind == 9);
      end
      idle(10);
      chk("rand_pkt_rise", rises - r0, 1);
      chk("rand_pkt_drain", exp_q.size(), 0);
    end

    chk("final_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_utm_rx_ctrl.md
Name: usb_utm_rx_ctrl

Overview:
- Receive sequencer for the FS UTM.
- Consumes the recovered line state, bit-center strobe, NRZI-decoded/unstuffed bitstream and stuff-error flag.
- Detects SYNC, assembles bytes LSB-first, detects EOP and handles error recovery.
- Drives the UTMI receive signals RxActive, RxValid, RxError and DataOut toward the SIE.

Parameters:
SYNC_MIN_ZEROS, 3, minimum decoded 0-bits before the terminating 1 for SYNC to be accepted (range 1..7)
DRIBBLE_MAX, 1, residual bits at EOP (bit_cnt != 0) tolerated silently
EOP_MAX_SE0, 2, maximum SE0 bit-samples accepted as a valid EOP
IDLE_J_BITS, 8, consecutive J samples required to leave ABORT

Ports:
clk  in  1  48 MHz sample clock
rst  in  1  asynchronous reset, active-high
rx_en  in  1  receive enable; low forces IDLE (deasserted by the SIE during transmit)
line_state  in  2  utmi_line_state_t: SE0=00, J=01, K=10, SE1=11
ls_valid  in  1  one-clk bit-center strobe (every 4 clk nominal)
dbit  in  1  decoded data bit
dbit_valid  in  1  dbit strobe; low for stuffed bits and non-J/K states
stuff_err  in  1  seventh consecutive 1 seen, coincident with the bit strobe
rx_active  out  1  UTMI RxActive
rx_valid  out  1  UTMI RxValid, one-clk pulse per byte
rx_error  out  1  UTMI RxError, one-clk pulse
data_out  out  8  UTMI DataOut

Behaviour:
- Reset values: rx_active=0, rx_valid=0, rx_error=0, data_out=8'h00, state=IDLE, all counters 0.
- All outputs are registered.
- FSM states: IDLE, SYNC, DATA, EOP, ABORT.
- Event precedence in every state: rx_en low > stuff_err > SE0/SE1 at ls_valid > dbit_valid.
- rx_en low, any state:
  - Next state IDLE, rx_active=0 next clk.
  - No rx_error; a partial byte is discarded.
- IDLE:
  - ls_valid with line_state==K: go to SYNC, zero_cnt=1. The J->K bit is the first 0.
  - Any other sample: stay.
- SYNC:
  - dbit_valid with dbit=0: zero_cnt++, saturating at 7.
  - dbit_valid with dbit=1 and zero_cnt>=SYNC_MIN_ZEROS: go to DATA; rx_active=1 the next clk; bit_cnt=0.
  - dbit_valid with dbit=1 and zero_cnt<SYNC_MIN_ZEROS: back to IDLE silently (noise).
  - SE0 or SE1 at ls_valid: back to IDLE silently.
  - stuff_err is ignored in SYNC.
- DATA:
  - dbit_valid: shift_reg <= {dbit, shift_reg[7:1]}; bit_cnt++ (3 bits, wraps).
  - On the 8th bit (bit_cnt 7->0): data_out <= assembled byte, rx_valid=1 for exactly one clk the next clk.
  - data_out holds until the next completed byte.
  - stuff_err: rx_error pulse next clk; go to ABORT; rx_active=0 one clk after the rx_error pulse.
  - SE1 at ls_valid: same as stuff_err.
  - SE0 at ls_valid:
    - bit_cnt in 0..DRIBBLE_MAX: go to EOP silently; residual bits discarded.
    - Otherwise: go to EOP and pulse rx_error.
  - se0_cnt=1 on EOP entry.
- EOP:
  - SE0 sample: se0_cnt++.
  - se0_cnt exceeds EOP_MAX_SE0: rx_error pulse, go to ABORT.
  - J sample: go to IDLE, rx_active=0 next clk.
  - K or SE1 sample: rx_error pulse, go to ABORT.
- ABORT:
  - rx_active=0.
  - j_cnt counts consecutive J samples and resets on any non-J.
  - j_cnt reaches IDLE_J_BITS: go to IDLE.
- Ordering guarantees:
  - rx_error and rx_valid are never asserted in the same clk.
  - The last rx_valid always precedes rx_active falling.
  - rx_active never rises and falls within 2 clk.
- Reset mid-packet: all outputs return to reset values immediately (asynchronous).

Decomposition:
- Package usb_utmi_pkg holds:
  - utmi_line_state_t (existing).
  - New enum usb_rx_state_t {RX_IDLE, RX_SYNC, RX_DATA, RX_EOP, RX_ABORT}.
  - Localparam USB_SYNC_PATTERN = 8'h80 (LSB-first received bit order 0000_0001).
- Single module, no sub-module. The byte shifter and counters are small enough to live inline with the FSM.
- usb_utm instantiates this block and maps its outputs onto the utmi interface rx fields.

Test Plan:
1. Idle J, then KJKJKJKK followed by NRZI for byte 0xA5 and SE0,SE0,J -> rx_active rises 1 clk after the final K's strobe; one rx_valid with data_out=8'hA5; rx_active falls 1 clk after the J sample; rx_error never asserted.
2. SYNC, bytes 0xC3 and 0x3F (stuffed bit after six 1s), EOP -> exactly two rx_valid pulses with 0xC3 then 0x3F; stuffed bit not counted.
3. SYNC then seven consecutive decoded 1s with stuff_err -> rx_error pulse; rx_active=0 next clk; no rx_valid; return to IDLE only after 8 J samples; 7 J then K keeps ABORT.
4. SYNC, one byte, 3 extra bits, SE0,SE0,J -> rx_error pulse with no extra rx_valid. Repeat with 1 extra bit -> no rx_error.
5. Glitch K,J,K(K) with only 1 zero before the terminating 1 -> rx_active stays 0; FSM returns to IDLE.
6. rx_en dropped mid-DATA after 4 bits -> rx_active=0 next clk, no rx_error. rst asserted mid-byte -> all outputs 0 asynchronously.
